// File: rtl/wb_queue.sv
// wb_queue: write-back queue between the execute/memory stages and the register file.
// Buffers ALU and load write requests in a small FIFO, retires one per cycle onto
// the register file write port, and flags read-after-write hazards for two read ports.
module wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_valid,
    input  logic [ADDR_W-1:0]          mem_reg,
    input  logic [DATA_W-1:0]          mem_data,
    output logic                       mem_ready,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_reg,
    input  logic [DATA_W-1:0]          alu_data,
    output logic                       alu_ready,
    output logic                       regwrite,
    output logic [ADDR_W-1:0]          writereg,
    output logic [DATA_W-1:0]          writedata,
    input  logic [ADDR_W-1:0]          readreg1,
    input  logic [ADDR_W-1:0]          readreg2,
    output logic                       hazard1,
    output logic                       hazard2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW:0] SPACE_DEPTH = (CW+1)'(DEPTH);
    localparam logic [CW:0] SPACE_ONE   = (CW+1)'(1);
    localparam logic [CW:0] SPACE_TWO   = (CW+1)'(2);

    logic [ADDR_W-1:0] fifo_reg  [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [PW-1:0]     alu_slot;
    logic [CW:0]       space;
    logic              pop;
    logic              mem_push;
    logic              alu_push;
    logic [DEPTH-1:0]  entry_valid;

    // Free space counts the head slot as free because it always drains on the same edge.
    // alu_ready looks only at count and mem_valid so no path loops back through alu_valid.
    always_comb begin
        pop       = (count != '0);
        space     = SPACE_DEPTH - {1'b0, count} + {{CW{1'b0}}, pop};
        mem_ready = (space >= SPACE_ONE);
        alu_ready = (space >= SPACE_TWO) || ((space == SPACE_ONE) && !mem_valid);
        mem_push  = mem_valid && mem_ready && (mem_reg != '0);
        alu_push  = alu_valid && alu_ready && (alu_reg != '0);
        alu_slot  = wptr + PW'(mem_push);
    end

    // Enqueue (load entry first, so it is older), retire the head, and track occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            regwrite  <= 1'b0;
            writereg  <= '0;
            writedata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_reg[i]  <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            if (mem_push) begin
                fifo_reg[wptr]  <= mem_reg;
                fifo_data[wptr] <= mem_data;
            end
            if (alu_push) begin
                fifo_reg[alu_slot]  <= alu_reg;
                fifo_data[alu_slot] <= alu_data;
            end
            wptr  <= wptr + PW'(mem_push) + PW'(alu_push);
            count <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
            if (pop) begin
                regwrite  <= 1'b1;
                writereg  <= fifo_reg[rptr];
                writedata <= fifo_data[rptr];
                rptr      <= rptr + PW'(1);
            end else begin
                regwrite <= 1'b0;
            end
        end
    end

    // A slot holds a pending write when its distance from the read pointer is below count.
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = ({1'b0, PW'(i) - rptr} < count);
        end
    end

    // Hazards compare read indices against stored entries and the write port only;
    // requests arriving this cycle are deliberately not considered.
    always_comb begin
        hazard1 = regwrite && (writereg == readreg1);
        hazard2 = regwrite && (writereg == readreg2);
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (fifo_reg[i] == readreg1)) begin
                hazard1 = 1'b1;
            end
            if (entry_valid[i] && (fifo_reg[i] == readreg2)) begin
                hazard2 = 1'b1;
            end
        end
        if (readreg1 == '0) begin
            hazard1 = 1'b0;
        end
        if (readreg2 == '0) begin
            hazard2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed self-checking bench for wb_queue (DEPTH=4, DATA_W=32, ADDR_W=5).
module tb_wb_queue;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        regwrite;
    logic [4:0]  writereg;
    logic [31:0] writedata;
    logic [4:0]  readreg1;
    logic [4:0]  readreg2;
    logic        hazard1;
    logic        hazard2;
    logic [2:0]  count;

    int total;
    int bad;

    logic [31:0] rf [32];

    wb_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .regwrite(regwrite), .writereg(writereg), .writedata(writedata),
        .readreg1(readreg1), .readreg2(readreg2),
        .hazard1(hazard1), .hazard2(hazard2), .count(count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Simple register file that captures the write port on the falling edge.
    always @(negedge clk) begin
        if (regwrite) rf[writereg] = writedata;
    end

    task test_reset;
        reset = 1'b1;
        mem_valid = 0; mem_reg = 0; mem_data = 0;
        alu_valid = 0; alu_reg = 0; alu_data = 0;
        readreg1 = 0; readreg2 = 0;
        #2;
        total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL reset_count got %0d want 0", count); end
        total++; if (regwrite !== 1'b0) begin bad++; $display("[TB] FAIL reset_regwrite got %b want 0", regwrite); end
        total++; if (writereg !== 5'd0) begin bad++; $display("[TB] FAIL reset_writereg got %0d want 0", writereg); end
        total++; if (writedata !== 32'd0) begin bad++; $display("[TB] FAIL reset_writedata got %h want 0", writedata); end
        total++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got %b%b want 11", mem_ready, alu_ready); end
        total++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin bad++; $display("[TB] FAIL reset_hazard got %b%b want 00", hazard1, hazard2); end
        reset = 1'b0;
    endtask

    task test_single;
        mem_valid = 1; mem_reg = 5'd5; mem_data = 32'hDEADBEEF;
        #1;
        total++; if (mem_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_ready got %b want 1", mem_ready); end
        @(posedge clk); #1;
        mem_valid = 0;
        total++; if (count !== 3'd1) begin bad++; $display("[TB] FAIL single_count1 got %0d want 1", count); end
        total++; if (regwrite !== 1'b0) begin bad++; $display("[TB] FAIL single_early got %b want 0", regwrite); end
        @(posedge clk); #1;
        total++; if (regwrite !== 1'b1) begin bad++; $display("[TB] FAIL single_regwrite got %b want 1", regwrite); end
        total++; if (writereg !== 5'd5) begin bad++; $display("[TB] FAIL single_writereg got %0d want 5", writereg); end
        total++; if (writedata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL single_writedata got %h want deadbeef", writedata); end
        total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL single_count0 got %0d want 0", count); end
        @(posedge clk); #1;
        total++; if (regwrite !== 1'b0) begin bad++; $display("[TB] FAIL single_idle got %b want 0", regwrite); end
        total++; if (writereg !== 5'd5) begin bad++; $display("[TB] FAIL single_hold got %0d want 5", writereg); end
    endtask

    task test_same_reg;
        readreg1 = 5'd3; readreg2 = 5'd4;
        mem_valid = 1; mem_reg = 5'd3; mem_data = 32'h11;
        alu_valid = 1; alu_reg = 5'd3; alu_data = 32'h22;
        #1;
        total++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin bad++; $display("[TB] FAIL same_ready got %b%b want 11", mem_ready, alu_ready); end
        total++; if (hazard1 !== 1'b0) begin bad++; $display("[TB] FAIL same_haz_incoming got %b want 0", hazard1); end
        @(posedge clk); #1;
        mem_valid = 0; alu_valid = 0;
        total++; if (count !== 3'd2) begin bad++; $display("[TB] FAIL same_count got %0d want 2", count); end
        total++; if (hazard1 !== 1'b1) begin bad++; $display("[TB] FAIL same_haz_q got %b want 1", hazard1); end
        total++; if (hazard2 !== 1'b0) begin bad++; $display("[TB] FAIL same_haz2_other got %b want 0", hazard2); end
        readreg2 = 5'd3;
        #1;
        total++; if (hazard2 !== 1'b1) begin bad++; $display("[TB] FAIL same_haz2 got %b want 1", hazard2); end
        @(posedge clk); #1;
        total++; if (regwrite !== 1'b1 || writereg !== 5'd3 || writedata !== 32'h11) begin bad++; $display("[TB] FAIL same_first got %b/%0d/%h want 1/3/11", regwrite, writereg, writedata); end
        total++; if (hazard1 !== 1'b1) begin bad++; $display("[TB] FAIL same_haz_mid got %b want 1", hazard1); end
        @(posedge clk); #1;
        total++; if (regwrite !== 1'b1 || writereg !== 5'd3 || writedata !== 32'h22) begin bad++; $display("[TB] FAIL same_second got %b/%0d/%h want 1/3/22", regwrite, writereg, writedata); end
        total++; if (hazard1 !== 1'b1) begin bad++; $display("[TB] FAIL same_haz_port got %b want 1", hazard1); end
        @(negedge clk); #1;
        total++; if (rf[3] !== 32'h22) begin bad++; $display("[TB] FAIL same_rf got %h want 22", rf[3]); end
        @(posedge clk); #1;
        total++; if (regwrite !== 1'b0 || hazard1 !== 1'b0 || hazard2 !== 1'b0) begin bad++; $display("[TB] FAIL same_clear got %b%b%b want 000", regwrite, hazard1, hazard2); end
        readreg1 = 0; readreg2 = 0;
    endtask

    task test_reg_zero;
        readreg1 = 5'd0;
        alu_valid = 1; alu_reg = 5'd0; alu_data = 32'hFFFFFFFF;
        #1;
        total++; if (alu_ready !== 1'b1) begin bad++; $display("[TB] FAIL zero_ready got %b want 1", alu_ready); end
        total++; if (hazard1 !== 1'b0) begin bad++; $display("[TB] FAIL zero_haz got %b want 0", hazard1); end
        @(posedge clk); #1;
        alu_valid = 0;
        total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL zero_count got %0d want 0", count); end
        total++; if (hazard1 !== 1'b0) begin bad++; $display("[TB] FAIL zero_haz_after got %b want 0", hazard1); end
        @(posedge clk); #1;
        total++; if (regwrite !== 1'b0) begin bad++; $display("[TB] FAIL zero_regwrite got %b want 0", regwrite); end
    endtask

    task test_back_to_back;
        logic [36:0] expq[$];
        logic [36:0] exp_e;
        int mcount;
        int space;
        int mi;
        int ai;
        int maxc;
        logic emr;
        logic ear;
        logic macc;
        logic aacc;
        mcount = 0; mi = 0; ai = 0; maxc = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            mem_valid = (cyc < 8); alu_valid = (cyc < 8);
            mem_reg = 5'(mi + 1);  mem_data = 32'h100 + 32'(mi);
            alu_reg = 5'(ai + 17); alu_data = 32'h200 + 32'(ai);
            #1;
            space = 4 - mcount + ((mcount != 0) ? 1 : 0);
            emr = (space >= 1);
            ear = (space >= 2) || (space == 1 && !mem_valid);
            total++; if (mem_ready !== emr) begin bad++; $display("[TB] FAIL b2b_mem_ready cyc=%0d got %b want %b", cyc, mem_ready, emr); end
            total++; if (alu_ready !== ear) begin bad++; $display("[TB] FAIL b2b_alu_ready cyc=%0d got %b want %b", cyc, alu_ready, ear); end
            macc = mem_valid && emr;
            aacc = alu_valid && ear;
            if (macc) begin expq.push_back({mem_reg, mem_data}); mi++; end
            if (aacc) begin expq.push_back({alu_reg, alu_data}); ai++; end
            @(posedge clk); #1;
            if (mcount != 0) begin
                exp_e = expq.pop_front();
                total++; if (regwrite !== 1'b1 || writereg !== exp_e[36:32] || writedata !== exp_e[31:0]) begin bad++; $display("[TB] FAIL b2b_retire cyc=%0d got %b/%0d/%h want 1/%0d/%h", cyc, regwrite, writereg, writedata, exp_e[36:32], exp_e[31:0]); end
            end else begin
                total++; if (regwrite !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle cyc=%0d got %b want 0", cyc, regwrite); end
            end
            mcount = mcount + (macc ? 1 : 0) + (aacc ? 1 : 0) - ((mcount != 0) ? 1 : 0);
            total++; if (count !== 3'(mcount)) begin bad++; $display("[TB] FAIL b2b_count cyc=%0d got %0d want %0d", cyc, count, mcount); end
            if (int'(count) > maxc) maxc = int'(count);
        end
        mem_valid = 0; alu_valid = 0;
        total++; if (maxc !== 4) begin bad++; $display("[TB] FAIL b2b_saturate got %0d want 4", maxc); end
    endtask

    task test_wrap;
        for (int c = 0; c <= 20; c++) begin
            mem_valid = (c < 20); mem_reg = 5'(c + 1); mem_data = 32'(c + 1);
            @(posedge clk); #1;
            if (c >= 1) begin
                total++; if (regwrite !== 1'b1 || writereg !== 5'(c) || writedata !== 32'(c)) begin bad++; $display("[TB] FAIL wrap_retire i=%0d got %b/%0d/%0d want 1/%0d/%0d", c, regwrite, writereg, writedata, c, c); end
            end
        end
        mem_valid = 0;
        total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL wrap_count got %0d want 0", count); end
        @(posedge clk); #1;
        total++; if (regwrite !== 1'b0) begin bad++; $display("[TB] FAIL wrap_idle got %b want 0", regwrite); end
    endtask

    task test_async_reset;
        mem_valid = 1; mem_reg = 5'd7; mem_data = 32'h77;
        alu_valid = 1; alu_reg = 5'd8; alu_data = 32'h88;
        @(posedge clk); #1;
        mem_reg = 5'd9;  mem_data = 32'h99;
        alu_reg = 5'd10; alu_data = 32'hAA;
        @(posedge clk); #1;
        mem_valid = 0; alu_valid = 0;
        total++; if (count !== 3'd3) begin bad++; $display("[TB] FAIL areset_fill got %0d want 3", count); end
        readreg1 = 5'd8; readreg2 = 5'd9;
        #2;
        reset = 1'b1;
        #1;
        total++; if (count !== 3'd0 || regwrite !== 1'b0) begin bad++; $display("[TB] FAIL areset_state got %0d/%b want 0/0", count, regwrite); end
        total++; if (writereg !== 5'd0 || writedata !== 32'd0) begin bad++; $display("[TB] FAIL areset_port got %0d/%h want 0/0", writereg, writedata); end
        total++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin bad++; $display("[TB] FAIL areset_ready got %b%b want 11", mem_ready, alu_ready); end
        total++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin bad++; $display("[TB] FAIL areset_hazard got %b%b want 00", hazard1, hazard2); end
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            total++; if (regwrite !== 1'b0 || count !== 3'd0) begin bad++; $display("[TB] FAIL areset_drain c=%0d got %b/%0d want 0/0", c, regwrite, count); end
        end
        readreg1 = 0; readreg2 = 0;
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_single;
        test_same_reg;
        test_reg_zero;
        test_back_to_back;
        test_wrap;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
